router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
Packet transmitter for the 1x3 router's input port. It accepts a command (payload length and destination address) and a byte stream of payload. It emits header, payload and parity on pkt_valid/tx_data, honouring the router's busy backpressure, and reports the router's parity-error verdict per packet. It sits between a test or host source and the router input.

Parameters:
FIFO_DEPTH, 64, payload buffer depth in bytes; must be at least 63 so a maximum-length packet buffers fully.
CNT_W, 7, width of the FIFO occupancy counter, equal to log2(FIFO_DEPTH)+1.

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_len  in  6  payload length, 1..63
cmd_addr  in  2  destination port, 0..2
pl_valid  in  1  payload byte offered
pl_ready  out  1  payload byte accepted when pl_valid && pl_ready
pl_data  in  8  payload byte
busy  in  1  router backpressure
err  in  1  router parity-error flag
pkt_valid  out  1  high during header and payload bytes, low on the parity byte
tx_data  out  8  byte presented to the router
cmd_err  out  1  one-cycle pulse: command rejected
pkt_done  out  1  one-cycle pulse: packet finished
pkt_err  out  1  valid with pkt_done: router flagged a parity error
pkt_cnt  out  8  packets completed, wraps 255 to 0

Behaviour:
- Reset is asynchronous and active-low. Every output goes to 0 immediately, the FIFO is flushed and the FSM returns to IDLE. Reset mid-packet aborts the packet with no pkt_done.
- All outputs are registered except pl_ready (= !fifo_full) and cmd_ready (= state==IDLE).
- Transfer rule: the byte on tx_data is consumed at a rising edge where busy==0. While busy==1, tx_data and pkt_valid hold.
- Payload FIFO: show-ahead and synchronous. A push happens on pl_valid && pl_ready; a pop happens when a payload byte is loaded onto tx_data. A simultaneous push and pop leaves the count unchanged. Pushes are allowed in every state.
- Header byte = {len, addr}. Parity = header XOR all payload bytes.
- FSM states and transitions:
  - IDLE: pkt_valid=0, tx_data=0. On command accept:
    - cmd_addr==3 or cmd_len==0: pulse cmd_err next cycle and stay in IDLE.
    - otherwise: latch len and addr, go to WAIT_DATA.
  - WAIT_DATA: when fifo_count >= len, register tx_data=header and pkt_valid=1, go to HEADER. The packet never starts until all of its payload is buffered, so the payload is never interrupted by an empty FIFO.
  - HEADER: on transfer, load the FIFO head onto tx_data, pop it, go to PAYLOAD.
  - PAYLOAD: on each transfer, fold the byte into parity and decrement the remaining count.
    - If more bytes remain, load the next FIFO byte.
    - After the last byte, register tx_data=parity and pkt_valid=0, go to PARITY.
  - PARITY: on transfer, set tx_data=0 and go to CHECK.
  - CHECK: minimum 2 cycles; stay until busy==0. err is OR-latched every cycle in CHECK. On exit, pulse pkt_done with pkt_err set to the latched value, increment pkt_cnt, and return to IDLE.
- Back-to-back packets: at least one IDLE cycle with pkt_valid=0 separates packets.
- Extra FIFO bytes beyond len remain buffered for the next packet.
- busy asserted while in IDLE or WAIT_DATA has no effect.

Decomposition:
- Shared package router_pkg holds:
  - state enum tx_state_t (IDLE, WAIT_DATA, HEADER, PAYLOAD, PARITY, CHECK)
  - ADDR_INVALID = 2'b11
  - MAX_LEN = 63
  - header-build helper function
- One sub-module: router_tx_fifo (show-ahead sync FIFO with occupancy count, parameterised by FIFO_DEPTH).

Test Plan:
- Push bytes 0..13, then cmd len=14 addr=0, busy=0 -> tx_data 0x38 with pkt_valid=1, then 0x00..0x0D, then 0x39 with pkt_valid=0; pkt_done with pkt_err=0; pkt_cnt=1.
- Cmd len=3 addr=1 with payload AA,55,0F; hold busy=1 for 3 cycles during the second payload byte -> 0x55 held stable, no duplicate; sequence 0x0D,AA,55,0F, then parity 0xFD.
- Cmd addr=3 len=5 -> cmd_err pulses one cycle, pkt_valid stays 0, FIFO count unchanged.
- Cmd len=10 with only 6 bytes buffered -> stays in WAIT_DATA with tx_data=0; header appears the cycle after the 10th push.
- Drive err=1 during CHECK -> pkt_done with pkt_err=1; the next packet with err=0 gives pkt_err=0.
- Deassert resetn mid-PAYLOAD -> pkt_valid and tx_data go to 0 immediately, no pkt_done, FIFO empty; a new packet afterwards is correct.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Imported by the top and the payload FIFO.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    HEADER,
    PAYLOAD,
    PARITY,
    CHECK
  } tx_state_t;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int MAX_LEN = 63;

  function automatic logic [7:0] build_header(
    input logic [5:0] len,
    input logic [1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Show-ahead synchronous payload FIFO with occupancy count.
// Head byte is always visible on dout; pointers reset to flush.
module router_tx_fifo
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 7
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: header, payload, parity,
// busy backpressure and per-packet parity-error report.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 7
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [5:0] cmd_len,
  input  logic [1:0] cmd_addr,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [7:0] tx_data,
  output logic       cmd_err,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic [7:0] pkt_cnt
);

  tx_state_t        state, state_n;
  logic [5:0]       len_q, len_n;
  logic [1:0]       addr_q, addr_n;
  logic [5:0]       rem_q, rem_n;
  logic [7:0]       par_q, par_n;
  logic             err_q, err_n;
  logic             chk_q, chk_n;
  logic [7:0]       tx_n;
  logic             pv_n;
  logic             cerr_n;
  logic             done_n;
  logic             perr_n;
  logic [7:0]       cnt_n;
  logic             pop;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;

  assign pl_ready  = !fifo_full;
  assign cmd_ready = (state == IDLE);

  router_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) u_fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (pl_valid && pl_ready),
    .din   (pl_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full)
  );

  always_comb begin
    state_n = state;
    len_n   = len_q;
    addr_n  = addr_q;
    rem_n   = rem_q;
    par_n   = par_q;
    err_n   = err_q;
    chk_n   = chk_q;
    tx_n    = tx_data;
    pv_n    = pkt_valid;
    cerr_n  = 1'b0;
    done_n  = 1'b0;
    perr_n  = 1'b0;
    cnt_n   = pkt_cnt;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = '0;
        pv_n = 1'b0;
        if (cmd_valid) begin
          if (cmd_addr == ADDR_INVALID || cmd_len == '0) begin
            cerr_n = 1'b1;
          end else begin
            len_n   = cmd_len;
            addr_n  = cmd_addr;
            state_n = WAIT_DATA;
          end
        end
      end
      // Start only once the whole payload is buffered.
      WAIT_DATA: begin
        if (fifo_count >= CNT_W'(len_q)) begin
          tx_n    = build_header(len_q, addr_q);
          pv_n    = 1'b1;
          par_n   = build_header(len_q, addr_q);
          rem_n   = len_q;
          state_n = HEADER;
        end
      end
      HEADER: begin
        if (!busy) begin
          tx_n    = fifo_dout;
          pop     = 1'b1;
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          par_n = par_q ^ tx_data;
          rem_n = rem_q - 6'd1;
          if (rem_q != 6'd1) begin
            tx_n = fifo_dout;
            pop  = 1'b1;
          end else begin
            tx_n    = par_q ^ tx_data;
            pv_n    = 1'b0;
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          tx_n    = '0;
          err_n   = 1'b0;
          chk_n   = 1'b0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        err_n = err_q | err;
        chk_n = 1'b1;
        if (chk_q && !busy) begin
          done_n  = 1'b1;
          perr_n  = err_q | err;
          cnt_n   = pkt_cnt + 8'd1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      par_q     <= '0;
      err_q     <= 1'b0;
      chk_q     <= 1'b0;
      tx_data   <= '0;
      pkt_valid <= 1'b0;
      cmd_err   <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      addr_q    <= addr_n;
      rem_q     <= rem_n;
      par_q     <= par_n;
      err_q     <= err_n;
      chk_q     <= chk_n;
      tx_data   <= tx_n;
      pkt_valid <= pv_n;
      cmd_err   <= cerr_n;
      pkt_done  <= done_n;
      pkt_err   <= perr_n;
      pkt_cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: packet-level model plus per-cycle
// output monitor and hand-computed literal expectations.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [5:0] cmd_len = '0;
  logic [1:0] cmd_addr = '0;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic [7:0] pl_data = '0;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       pkt_valid;
  logic [7:0] tx_data;
  logic       cmd_err;
  logic       pkt_done;
  logic       pkt_err;
  logic [7:0] pkt_cnt;

  router_pkt_tx dut (
    .clock    (clock),
    .resetn   (resetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .cmd_addr (cmd_addr),
    .pl_valid (pl_valid),
    .pl_ready (pl_ready),
    .pl_data  (pl_data),
    .busy     (busy),
    .err      (err),
    .pkt_valid(pkt_valid),
    .tx_data  (tx_data),
    .cmd_err  (cmd_err),
    .pkt_done (pkt_done),
    .pkt_err  (pkt_err),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_m[$];
  int         pend_len[$];
  int         pend_addr[$];
  logic [7:0] obs[$];
  int         checks = 0;
  int         passed = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // Packet model: a command becomes a byte list once its payload exists.
  task automatic try_form();
    while (pend_len.size() > 0 && fifo_m.size() >= pend_len[0]) begin
      int l = pend_len.pop_front();
      int a = pend_addr.pop_front();
      logic [7:0] p;
      exp_t e;
      p = 8'(l * 4 + a);
      e = '{p, 1'b1, 1'b0};
      exp_q.push_back(e);
      for (int i = 0; i < l; i++) begin
        logic [7:0] b = fifo_m.pop_front();
        p = p ^ b;
        e = '{b, 1'b1, 1'b0};
        exp_q.push_back(e);
      end
      e = '{p, 1'b0, 1'b1};
      exp_q.push_back(e);
    end
  endtask

  // Per-cycle monitor
  logic       mon_in = 0, mon_wait = 0, hold_pend = 0;
  logic [7:0] hold_data;
  logic       hold_valid;
  logic       err_acc = 0, last_busy = 1;
  int         wait_n = 0;
  logic [7:0] exp_cnt = 0;

  always @(negedge clock) begin
    exp_t e;
    if (!resetn) begin
      mon_in = 0;
      mon_wait = 0;
      hold_pend = 0;
      exp_cnt = 0;
    end else begin
      if (hold_pend)
        check(tx_data == hold_data && pkt_valid == hold_valid, "busy_hold",
              {pkt_valid, tx_data}, {hold_valid, hold_data});
      hold_pend = 0;
      if (pkt_done) begin
        check(mon_wait, "done_expected", pkt_done, mon_wait);
        if (mon_wait) begin
          exp_cnt = exp_cnt + 8'd1;
          check(pkt_err == err_acc, "pkt_err", pkt_err, err_acc);
          check(pkt_cnt == exp_cnt, "pkt_cnt", pkt_cnt, exp_cnt);
          check(wait_n >= 2 && !last_busy, "check_phase", wait_n, 2);
          mon_wait = 0;
        end
      end else if (mon_wait) begin
        err_acc = err_acc | err;
        last_busy = busy;
        wait_n++;
        if (wait_n > 200) begin
          check(0, "done_timeout", wait_n, 200);
          mon_wait = 0;
        end
      end
      if (!mon_in) begin
        if (pkt_valid && !mon_wait) mon_in = 1;
        else check(tx_data == 0 && pkt_valid == 0, "idle_out",
                   {pkt_valid, tx_data}, 0);
      end
      if (mon_in) begin
        if (busy) begin
          hold_pend = 1;
          hold_data = tx_data;
          hold_valid = pkt_valid;
        end else if (exp_q.size() == 0) begin
          check(0, "unexpected_byte", tx_data, 0);
          mon_in = 0;
        end else begin
          e = exp_q.pop_front();
          check(tx_data == e.data && pkt_valid == e.valid, "tx_byte",
                {pkt_valid, tx_data}, {e.valid, e.data});
          obs.push_back(tx_data);
          if (e.last) begin
            mon_in = 0;
            mon_wait = 1;
            err_acc = 0;
            wait_n = 0;
            last_busy = 1;
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    check(pl_ready === 1'b1, "pl_ready", pl_ready, 1);
    pl_valid = 1;
    pl_data = b;
    @(posedge clock);
    #1;
    pl_valid = 0;
    fifo_m.push_back(b);
    try_form();
  endtask

  task automatic send_cmd(input int len, input int addr);
    int n = 0;
    cmd_valid = 1;
    cmd_len = 6'(len);
    cmd_addr = 2'(addr);
    while (!cmd_ready && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!cmd_ready) check(0, "cmd_timeout", n, 300);
    @(posedge clock);
    #1;
    cmd_valid = 0;
    if (addr != 3 && len != 0) begin
      pend_len.push_back(len);
      pend_addr.push_back(addr);
      try_form();
    end
  endtask

  task automatic wait_done(output logic perr);
    int n = 0;
    while (!pkt_done && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(pkt_done, "wait_done", n, 500);
    perr = pkt_err;
  endtask

  task automatic wait_tx(input logic [7:0] v, input logic pv);
    int n = 0;
    while (!(pkt_valid == pv && tx_data == v) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(pkt_valid == pv && tx_data == v, "wait_tx",
          {pkt_valid, tx_data}, {pv, v});
  endtask

  initial begin
    logic perr;
    #1;
    check(pkt_valid == 0 && tx_data == 0, "reset_tx", {pkt_valid, tx_data}, 0);
    check({cmd_err, pkt_done, pkt_err} == 0 && pkt_cnt == 0, "reset_flags",
          {cmd_err, pkt_done, pkt_err, pkt_cnt}, 0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1;
    @(posedge clock);
    #1;

    // 14-byte packet to port 0
    obs.delete();
    for (int i = 0; i < 14; i++) push(8'(i));
    send_cmd(14, 0);
    wait_done(perr);
    check(perr == 0, "t1_err", perr, 0);
    check(pkt_cnt == 8'd1, "t1_cnt", pkt_cnt, 1);
    check(obs.size() == 16, "t1_len", obs.size(), 16);
    check(obs[0] == 8'h38, "t1_hdr", obs[0], 8'h38);
    check(obs[14] == 8'h0D, "t1_last", obs[14], 8'h0D);
    check(obs[15] == 8'h39, "t1_par", obs[15], 8'h39);

    // busy held on the second payload byte
    obs.delete();
    push(8'hAA);
    push(8'h55);
    push(8'h0F);
    send_cmd(3, 1);
    wait_tx(8'h55, 1'b1);
    busy = 1;
    repeat (3) begin
      @(posedge clock);
      #1;
      check(tx_data == 8'h55 && pkt_valid, "t2_hold", tx_data, 8'h55);
    end
    busy = 0;
    wait_done(perr);
    check(obs.size() == 5, "t2_len", obs.size(), 5);
    check(obs[0] == 8'h0D && obs[1] == 8'hAA, "t2_b01",
          {obs[0], obs[1]}, 16'h0DAA);
    check(obs[2] == 8'h55 && obs[3] == 8'h0F, "t2_b23",
          {obs[2], obs[3]}, 16'h550F);
    check(obs[4] == 8'hFD, "t2_par", obs[4], 8'hFD);

    // rejected commands
    send_cmd(5, 3);
    check(cmd_err == 1 && pkt_valid == 0, "t3_err", {cmd_err, pkt_valid}, 2);
    @(posedge clock);
    #1;
    check(cmd_err == 0, "t3_pulse", cmd_err, 0);
    send_cmd(0, 1);
    check(cmd_err == 1, "t3_len0", cmd_err, 1);
    @(posedge clock);
    #1;

    // command waits for its payload
    send_cmd(10, 2);
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    repeat (3) begin
      @(posedge clock);
      #1;
      check(pkt_valid == 0 && tx_data == 0, "t4_wait", {pkt_valid, tx_data}, 0);
    end
    for (int i = 6; i < 10; i++) push(8'(8'h10 + i));
    check(pkt_valid == 0, "t4_pre", pkt_valid, 0);
    @(posedge clock);
    #1;
    check(pkt_valid == 1 && tx_data == 8'h2A, "t4_hdr",
          {pkt_valid, tx_data}, 9'h12A);
    wait_done(perr);

    // router error latched in CHECK
    for (int i = 1; i <= 4; i++) push(8'(i));
    send_cmd(4, 0);
    wait_tx(8'h10, 1'b1);
    wait_tx(8'h14, 1'b0);
    @(posedge clock);
    #1;
    err = 1;
    @(posedge clock);
    #1;
    err = 0;
    wait_done(perr);
    check(perr == 1, "t5_err1", perr, 1);
    push(8'h21);
    push(8'h42);
    send_cmd(2, 2);
    wait_done(perr);
    check(perr == 0, "t5_err0", perr, 0);

    // reset mid-payload
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
    for (int i = 0; i < 3; i++) push(8'(8'h90 + i));
    send_cmd(8, 1);
    wait_tx(8'h82, 1'b1);
    #2;
    resetn = 0;
    #1;
    check(pkt_valid == 0 && tx_data == 0, "t6_rst_tx", {pkt_valid, tx_data}, 0);
    check(pkt_cnt == 0 && pkt_done == 0, "t6_rst_cnt", {pkt_done, pkt_cnt}, 0);
    fifo_m.delete();
    pend_len.delete();
    pend_addr.delete();
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1;
    check(cmd_ready && pl_ready, "t6_ready", {cmd_ready, pl_ready}, 3);
    @(posedge clock);
    #1;
    obs.delete();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    send_cmd(3, 2);
    wait_done(perr);
    check(pkt_cnt == 8'd1, "t6_cnt", pkt_cnt, 1);
    check(obs.size() == 5, "t6_len", obs.size(), 5);
    check(obs[0] == 8'h0E && obs[1] == 8'h11, "t6_head",
          {obs[0], obs[1]}, 16'h0E11);
    check(obs[4] == 8'h0E, "t6_par", obs[4], 8'h0E);

    repeat (3) @(posedge clock);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
